// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared word size, 2-bit counter encodings and PC increment helper
package branch_predictor_pkg;
    localparam int WORD_SIZE = 16;
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;
    function automatic logic [WORD_SIZE-1:0] pc_inc(input logic [WORD_SIZE-1:0] pc);
        return pc + WORD_SIZE'(1);
    endfunction
endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating taken/not-taken counter
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] next
);
    always_comb begin
        next = taken ? ((cur == ST) ? ST : cur + 2'd1)
                     : ((cur == SNT) ? SNT : cur - 2'd1);
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, combinational lookup and mispredict detect
// Optional resolved/mispredict statistics counters when BP_STATS_EN is defined.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_uncond,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_pred_taken,
    input  logic [WORD_SIZE-1:0] upd_pred_next_pc,
    output logic                 mispredict
`ifdef BP_STATS_EN
    ,
    output logic [15:0]          stat_resolved,
    output logic [15:0]          stat_mispredicts
`endif
);
    localparam int ENTRIES  = 2**INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

    logic                 valid  [ENTRIES];
    logic [TAG_BITS-1:0]  tag    [ENTRIES];
    logic [WORD_SIZE-1:0] target [ENTRIES];
    logic [1:0]           ctr    [ENTRIES];

    logic [INDEX_BITS-1:0] lidx, uidx;
    logic [TAG_BITS-1:0]   ltag, utag;
    logic                  lhit, uhit, eff_taken;
    logic [WORD_SIZE-1:0]  res_next;
    logic [1:0]            sat_next;

    always_comb begin
        lidx         = if_pc[INDEX_BITS-1:0];
        ltag         = if_pc[WORD_SIZE-1:INDEX_BITS];
        lhit         = valid[lidx] && (tag[lidx] == ltag);
        pred_taken   = lhit && ctr[lidx][1];
        pred_next_pc = pred_taken ? target[lidx] : pc_inc(if_pc);
    end

    // Unconditional jumps resolve as taken whatever upd_taken says.
    always_comb begin
        uidx       = upd_pc[INDEX_BITS-1:0];
        utag       = upd_pc[WORD_SIZE-1:INDEX_BITS];
        uhit       = valid[uidx] && (tag[uidx] == utag);
        eff_taken  = upd_taken || upd_uncond;
        res_next   = eff_taken ? upd_target : pc_inc(upd_pc);
        mispredict = upd_valid && ((eff_taken != upd_pred_taken) || (res_next != upd_pred_next_pc));
    end

    sat_counter2 u_sat (
        .cur   (ctr[uidx]),
        .taken (upd_taken),
        .next  (sat_next)
    );

    // A not-taken miss falls through every branch below and leaves the entry untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= WNT;
            end
        end else if (upd_valid) begin
            if (uhit || eff_taken) begin
                valid[uidx] <= 1'b1;
                tag[uidx]   <= utag;
            end
            if (eff_taken)
                target[uidx] <= upd_target;
            ctr[uidx] <= upd_uncond ? ST : uhit ? sat_next : upd_taken ? WT : ctr[uidx];
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_resolved    <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            stat_resolved    <= stat_resolved + {15'd0, stat_resolved != 16'hFFFF};
            stat_mispredicts <= stat_mispredicts + {15'd0, mispredict && (stat_mispredicts != 16'hFFFF)};
        end
    end
`endif
endmodule
